regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port integer register file with write-through bypass and a per-register busy scoreboard. It is the next generation of the core's integer register file. It sits between decode (reads and destination allocation) and writeback (result write). Decode uses the busy bits to stall on RAW hazards against multi-cycle producers. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NREAD, 2, number of combinational read ports, at least 1
- BYPASS, 1, 1 means a same-cycle write is forwarded to matching reads; 0 means reads return stored contents only
- AW, $clog2(NREGS), derived address width; not overridable
- CW, $clog2(NREGS+1), derived busy-count width; not overridable

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NREAD*AW  read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data; port i is bits [i*XLEN +: XLEN]
- rd_busy  out  NREAD  busy flag per read port
- we  in  1  writeback valid
- waddr  in  AW  writeback register
- wdata  in  XLEN  writeback data
- alloc  in  1  mark destination register pending
- alloc_addr  in  AW  register to mark
- busy_cnt  out  CW  number of registers currently busy

## Operation
- State: NREGS×XLEN data array and NREGS busy bits (busy_q).
- Reset (rst_n low, asynchronous): all data entries become 0 and all busy_q become 0.
- Write: on a rising edge with we=1 and waddr≠0, data[waddr] ← wdata and busy_q[waddr] ← 0. A write with waddr=0 is ignored completely.
- Alloc: on a rising edge with alloc=1 and alloc_addr≠0, busy_q[alloc_addr] ← 1. An alloc with alloc_addr=0 is ignored.
- Simultaneous write and alloc to the same register:
  - Data is written.
  - busy_q ends at 1, because the alloc belongs to a newer producer.
- Alloc to a register that is already busy: busy stays 1. This is not an error; there is no counting per register.
- Read port i (combinational):
  - rd_addr_i=0 gives rd_data_i=0 and rd_busy_i=0.
  - With BYPASS=1, we=1 and waddr=rd_addr_i≠0: rd_data_i=wdata and rd_busy_i=0.
  - Otherwise rd_data_i=data[rd_addr_i] and rd_busy_i=busy_q[rd_addr_i].
- Same-cycle alloc does not affect read outputs. It becomes visible in the next cycle.
- busy_cnt is a registered population count of busy_q, maintained incrementally each cycle:
  - +1 when the alloc target was not busy.
  - −1 when a valid write clears a busy register that is not also being re-allocated.
  - Net 0 when both apply to different registers.
- busy_cnt never exceeds NREGS−1.
- busy_cnt resets to 0.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, we, waddr and wdata).
- Write and alloc latency is 1 cycle: visible on reads in the cycle after the edge.
- With BYPASS=1, the write is also visible in the same cycle.
- busy_cnt updates on the same edge as busy_q, with no extra lag.
- Reset assertion mid-operation clears everything immediately, regardless of clk.
- Deassertion is synchronised externally. The first edge after deassertion may write or alloc.
- There is no handshake. The caller guarantees at most one write and one alloc per cycle.

## Structure
- A shared package holds the defaults, the rule that register 0 is always zero, and a function that packs and unpacks per-port addresses.
- One sub-module is natural: regfile_sb_scoreboard. It holds busy_q, the alloc/write clear logic and busy_cnt.
- The data array and the read/bypass muxes stay in the top module, generated over NREAD.

## Test plan
- Reset with the array pre-filled by writes, then rst_n=0 for half a cycle: all reads return 0, rd_busy=0, busy_cnt=0, applied asynchronously.
- BYPASS=1: we=1, waddr=5, wdata=0xDEADBEEF, rd_addr0=5 in the same cycle → rd_data0=0xDEADBEEF immediately. BYPASS=0: the same read gives the old value until the next cycle.
- Register 0: write 0x1234 to x0 and alloc x0 → next-cycle read of x0 is 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: alloc x7 → next cycle rd_busy=1 and busy_cnt=1. Write x7=0x55 → next cycle rd_busy=0, data 0x55, busy_cnt=0.
- Simultaneous write and alloc of x9 (x9 initially busy) → data updated, x9 stays busy, busy_cnt unchanged. Write x3 plus alloc x4 with x3 busy and x4 free → busy_cnt net unchanged.
- NREAD=3, XLEN=64, NREGS=16: three ports read x1, x15 and x0 after writes → correct 64-bit values, 0 on the x0 port, and busy_cnt width is 5.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared defaults and helpers for the scoreboarded register file
// Purpose: parameter defaults, the hardwired-zero register rule and the
//          per-port packing helper used by regfile_sb and its scoreboard.
// Ports:   none (package)
package regfile_sb_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_BYPASS = 1;

  // Architectural register that always reads zero and never goes busy.
  localparam int ZERO_REG = 0;

  function automatic logic is_zero_reg(input logic [31:0] addr);
    return addr == 32'(ZERO_REG);
  endfunction

  // LSB of field 'port' inside a flat vector of 'width'-bit fields; used both
  // to unpack read addresses and to pack read data.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - per-register busy bits and busy population count
// Purpose: tracks which registers await a multi-cycle producer.
// Ports:   clk, rst_n            clock, async active-low reset
//          we, waddr             writeback clears busy
//          alloc, alloc_addr     destination allocation sets busy
//          busy_q                NREGS busy bits (bit 0 always 0)
//          busy_cnt              registered count of set busy bits
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             alloc,
  input  logic [AW-1:0]    alloc_addr,
  output logic [NREGS-1:0] busy_q,
  output logic [CW-1:0]    busy_cnt
);

  logic             write_v;
  logic             alloc_v;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [NREGS-1:0] busy_d;

  assign write_v = we && !is_zero_reg(32'(waddr));
  assign alloc_v = alloc && !is_zero_reg(32'(alloc_addr));

  // Alloc is applied after the write clear so a same-register pair stays busy
  // (the alloc belongs to a newer producer).
  always_comb begin
    busy_d = busy_q;
    if (write_v) busy_d[waddr] = 1'b0;
    if (alloc_v) busy_d[alloc_addr] = 1'b1;
  end

  // Incremental count: only genuine 0->1 and 1->0 transitions move it.
  assign cnt_inc = alloc_v && !busy_q[alloc_addr];
  assign cnt_dec = write_v && busy_q[waddr] && !(alloc_v && (alloc_addr == waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port integer register file with bypass and busy scoreboard
// Purpose: NREGS x XLEN register array, NREAD combinational read ports with
//          optional same-cycle write forwarding, and busy tracking for decode.
// Ports:   clk, rst_n            clock, async active-low reset
//          rd_addr, rd_data      packed per-port read address / data
//          rd_busy               per-port busy flag
//          we, waddr, wdata      writeback
//          alloc, alloc_addr     destination allocation
//          busy_cnt              number of busy registers
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NREAD  = DEF_NREAD,
  parameter  int BYPASS = DEF_BYPASS,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(NREGS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  alloc,
  input  logic [AW-1:0]         alloc_addr,
  output logic [CW-1:0]         busy_cnt
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy_q;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (we && !is_zero_reg(32'(waddr))) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_sb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .alloc      (alloc),
    .alloc_addr (alloc_addr),
    .busy_q     (busy_q),
    .busy_cnt   (busy_cnt)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd_port
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbsy;

    assign ra = rd_addr[port_lsb(i, AW) +: AW];

    always_comb begin
      rdat = mem[ra];
      rbsy = busy_q[ra];
      if (is_zero_reg(32'(ra))) begin
        rdat = '0;
        rbsy = 1'b0;
      end else if ((BYPASS != 0) && we && (waddr == ra)) begin
        // Forwarded write also retires the producer, so the port is not busy.
        rdat = wdata;
        rbsy = 1'b0;
      end
    end

    assign rd_data[port_lsb(i, XLEN) +: XLEN] = rdat;
    assign rd_busy[i] = rbsy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: XLEN 32, NREGS 32, NREAD 2, BYPASS 1
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        alloc;
  logic [4:0]  alloc_addr;
  logic [5:0]  busy_cnt;

  // Wide configuration: XLEN 64, NREGS 16, NREAD 3, BYPASS 0
  logic [11:0]  rd_addr1;
  logic [191:0] rd_data1;
  logic [2:0]   rd_busy1;
  logic         we1;
  logic [3:0]   waddr1;
  logic [63:0]  wdata1;
  logic         alloc1;
  logic [3:0]   alloc_addr1;
  logic [4:0]   busy_cnt1;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc(alloc), .alloc_addr(alloc_addr),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .we(we1), .waddr(waddr1), .wdata(wdata1), .alloc(alloc1), .alloc_addr(alloc_addr1),
    .busy_cnt(busy_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the default instance: architectural contents and busy set.
  logic [31:0] m_data [32];
  logic        m_busy [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_data[r] <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      if (we && waddr != 0) begin
        m_data[waddr] <= wdata;
        m_busy[waddr] <= 1'b0;
      end
      if (alloc && alloc_addr != 0) m_busy[alloc_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0]  a;
    logic [31:0] ed;
    logic        eb;
    int          cnt;
    if (rst_n && chk_on) begin
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*5 +: 5];
        if (a == 0) begin
          ed = '0; eb = 1'b0;
        end else if (we && waddr == a) begin
          ed = wdata; eb = 1'b0;
        end else begin
          ed = m_data[a]; eb = m_busy[a];
        end
        check("model_rd_data", 64'(rd_data[p*32 +: 32]), 64'(ed));
        check("model_rd_busy", 64'(rd_busy[p]), 64'(eb));
      end
      cnt = 0;
      for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
      check("model_busy_cnt", 64'(busy_cnt), 64'(cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_addr = '0; we = 0; waddr = '0; wdata = '0; alloc = 0; alloc_addr = '0;
    rd_addr1 = '0; we1 = 0; waddr1 = '0; wdata1 = '0; alloc1 = 0; alloc_addr1 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;

    // Prefill, then asynchronous reset in the middle of a cycle
    we = 1; waddr = 5; wdata = 32'h11; alloc = 1; alloc_addr = 8;
    step();
    waddr = 6; wdata = 32'h22; alloc = 0;
    step();
    we = 0; rd_addr = {5'd6, 5'd5};
    #2;
    check("prefill_x5", 64'(rd_data[31:0]), 64'h11);
    check("prefill_x6", 64'(rd_data[63:32]), 64'h22);
    check("prefill_cnt", 64'(busy_cnt), 64'd1);
    rd_addr = {5'd8, 5'd5};
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_x5", 64'(rd_data[31:0]), 64'h0);
    check("reset_busy_x8", 64'(rd_busy[1]), 64'h0);
    check("reset_cnt", 64'(busy_cnt), 64'h0);
    #2 rst_n = 1'b1;
    step();

    // Wide instance holds an old value of x5
    we1 = 1; waddr1 = 5; wdata1 = 64'h1111;
    step();

    // Same-cycle write: forwarded with bypass, old value without
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    we1 = 1; waddr1 = 5; wdata1 = 64'hDEADBEEF; rd_addr1 = {4'd0, 4'd0, 4'd5};
    #2;
    check("bypass_on_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("bypass_on_busy", 64'(rd_busy[0]), 64'h0);
    check("bypass_off_old", rd_data1[63:0], 64'h1111);
    step();
    we = 0; we1 = 0;
    #2;
    check("bypass_off_next", rd_data1[63:0], 64'hDEADBEEF);
    check("write_visible", 64'(rd_data[31:0]), 64'hDEADBEEF);
    step();

    // Register 0 ignores write and alloc
    we = 1; waddr = 0; wdata = 32'h1234; alloc = 1; alloc_addr = 0; rd_addr = '0;
    step();
    we = 0; alloc = 0;
    #2;
    check("x0_data", 64'(rd_data[31:0]), 64'h0);
    check("x0_busy", 64'(rd_busy[0]), 64'h0);
    check("x0_cnt", 64'(busy_cnt), 64'h0);

    // Alloc then writeback of x7
    alloc = 1; alloc_addr = 7;
    step();
    alloc = 0; rd_addr = {5'd0, 5'd7};
    #2;
    check("x7_busy", 64'(rd_busy[0]), 64'h1);
    check("x7_cnt", 64'(busy_cnt), 64'h1);
    we = 1; waddr = 7; wdata = 32'h55;
    step();
    we = 0;
    #2;
    check("x7_wb_busy", 64'(rd_busy[0]), 64'h0);
    check("x7_wb_data", 64'(rd_data[31:0]), 64'h55);
    check("x7_wb_cnt", 64'(busy_cnt), 64'h0);

    // Write and re-alloc of an already busy x9
    alloc = 1; alloc_addr = 9;
    step();
    we = 1; waddr = 9; wdata = 32'hABCD; alloc = 1; alloc_addr = 9;
    step();
    we = 0; alloc = 0; rd_addr = {5'd0, 5'd9};
    #2;
    check("x9_data", 64'(rd_data[31:0]), 64'hABCD);
    check("x9_busy", 64'(rd_busy[0]), 64'h1);
    check("x9_cnt", 64'(busy_cnt), 64'h1);

    // Clear x3 while allocating x4: net count unchanged
    alloc = 1; alloc_addr = 3;
    step();
    we = 1; waddr = 3; wdata = 32'h77; alloc = 1; alloc_addr = 4;
    step();
    we = 0; alloc = 0; rd_addr = {5'd4, 5'd3};
    #2;
    check("x3x4_cnt", 64'(busy_cnt), 64'h2);
    check("x3_busy", 64'(rd_busy[0]), 64'h0);
    check("x4_busy", 64'(rd_busy[1]), 64'h1);

    // Wide instance: three ports, 64-bit data
    we1 = 1; waddr1 = 1; wdata1 = 64'h0123456789ABCDEF;
    step();
    waddr1 = 15; wdata1 = 64'hFEDCBA9876543210;
    step();
    we1 = 0; rd_addr1 = {4'd0, 4'd15, 4'd1};
    #2;
    check("wide_x1", rd_data1[63:0], 64'h0123456789ABCDEF);
    check("wide_x15", rd_data1[127:64], 64'hFEDCBA9876543210);
    check("wide_x0", rd_data1[191:128], 64'h0);

    // Wide instance: every allocatable register busy, then re-alloc one
    for (int r = 1; r < 16; r++) begin
      alloc1 = 1; alloc_addr1 = 4'(r);
      step();
    end
    alloc1 = 0;
    #2;
    check("wide_cnt_full", 64'(busy_cnt1), 64'd15);
    alloc1 = 1; alloc_addr1 = 3;
    step();
    alloc1 = 0;
    #2;
    check("wide_cnt_realloc", 64'(busy_cnt1), 64'd15);

    // Randomized traffic on the default instance, checked by the model
    for (int c = 0; c < 3000; c++) begin
      we    = 1'($urandom_range(0, 1));
      alloc = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 1) == 1) begin
        waddr = 5'($urandom_range(0, 7)); alloc_addr = 5'($urandom_range(0, 7));
        rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      end else begin
        waddr = 5'($urandom_range(0, 31)); alloc_addr = 5'($urandom_range(0, 31));
        rd_addr = 10'($urandom);
      end
      wdata = $urandom;
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
      end
      step();
    end
    we = 0; alloc = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
